// File: rtl/sdf_butterfly.sv
// sdf_butterfly
// Radix-2 single-path delay-feedback butterfly stage of the streaming FFT.
// Each frame of 2*DELAY samples is handled in two phases:
//   - In the first half, samples are parked in the delay line.
//   - In the second half, each incoming sample b meets its partner a at the
//     delay-line head. The stage emits the scaled sum (a+b)/2 and parks the
//     scaled difference (a-b)/2.
// The parked differences come out during the first half of the next frame,
// or during a drain triggered by flush.
//
// Configuration macro: SDF_ROUND_EN
//   defined   : round half up before the divide by two
//   undefined : truncate (floor)
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   in_valid   : in_data is valid (accepted when in_valid & in_ready)
//   in_ready   : low only while draining held differences
//   in_data    : packed complex {re[23:12], im[11:0]}, two's complement
//   flush      : one-cycle request to drain at the next frame boundary
//   out_valid  : out_data is valid this cycle
//   out_data   : packed complex result, same format as in_data
//   out_tw_idx : twiddle index for out_data (0 for sums)
//   out_sof    : high with the first sum of each frame
module sdf_butterfly #(
   parameter int DELAY = 4,
   parameter int AW    = $clog2(DELAY)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [23:0]   in_data,
   input  logic          flush,
   output logic          out_valid,
   output logic [23:0]   out_data,
   output logic [AW-1:0] out_tw_idx,
   output logic          out_sof
);

   localparam int CW = AW + 1;
   localparam logic [CW-1:0] LAST_P0  = CW'(DELAY - 1);
   localparam logic [CW-1:0] FIRST_P1 = CW'(DELAY);
   localparam logic [CW-1:0] LAST_P1  = CW'(2 * DELAY - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          primed_q, primed_d;
   logic          flush_pend_q, flush_pend_d;
   logic [23:0]   dline [DELAY];
   logic          advance;
   logic          phase1;
   logic [23:0]   sample;
   logic [23:0]   head;
   logic [23:0]   sum_val;
   logic [23:0]   diff_val;
   logic [23:0]   push_val;

   // Divide a 13-bit signed sum or difference by two, optionally rounding
   // half up, and keep the low 12 bits of the arithmetic shift.
   function automatic logic [11:0] halve(input logic [12:0] v);
      logic [12:0] r;
`ifdef SDF_ROUND_EN
      r = v + 13'd1;
`else
      r = v;
`endif
      return 12'($signed(r) >>> 1);
   endfunction

   // During a drain the stage clocks itself with zero input, so the held
   // differences walk out of the delay line without needing upstream data.
   // The top counter bit distinguishes the two halves of the frame,
   // because DELAY is a power of two.
   assign in_ready = (state_q != DRAIN);
   assign advance  = (state_q == DRAIN) || (in_valid && in_ready);
   assign sample   = (state_q == DRAIN) ? 24'd0 : in_data;
   assign phase1   = cnt_q[AW];
   assign head     = dline[DELAY-1];

   assign sum_val  = {halve({head[23], head[23:12]} + {sample[23], sample[23:12]}),
                      halve({head[11], head[11:0]}  + {sample[11], sample[11:0]})};
   assign diff_val = {halve({head[23], head[23:12]} - {sample[23], sample[23:12]}),
                      halve({head[11], head[11:0]}  - {sample[11], sample[11:0]})};
   assign push_val = phase1 ? diff_val : sample;

   // The delay line shifts by one entry on every advance.
   // Raw samples enter in the first half of a frame and differences enter in
   // the second half. The oldest entry is always at dline[DELAY-1].
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DELAY; i++) begin
            dline[i] <= '0;
         end
      end else if (advance) begin
         dline[0] <= push_val;
         for (int i = 1; i < DELAY; i++) begin
            dline[i] <= dline[i-1];
         end
      end
   end

   // State, frame counter, primed flag and pending-flush latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         primed_q     <= 1'b0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         primed_q     <= primed_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   // Next-state logic.
   // The counter wraps every 2*DELAY advances. Once a full frame has passed,
   // primed stays set, so first-half outputs carry real differences.
   // A pending flush is only acted on at a frame boundary, and only when
   // upstream has nothing to offer. An arriving sample always wins and
   // leaves the flush pending for the next boundary. A drain lasts DELAY
   // advances, after which the stage forgets its history.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      primed_d     = primed_q;
      flush_pend_d = flush_pend_q;

      if (advance) begin
         cnt_d = (cnt_q == LAST_P1) ? '0 : cnt_q + 1'b1;
         if (cnt_q == LAST_P1) begin
            primed_d = 1'b1;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (flush) begin
               flush_pend_d = 1'b1;
            end
            if ((cnt_q == '0) && flush_pend_q) begin
               if (!primed_q) begin
                  flush_pend_d = 1'b0;
               end else if (!in_valid) begin
                  state_d      = DRAIN;
                  flush_pend_d = 1'b0;
               end
            end
         end
         DRAIN: begin
            if (cnt_q == LAST_P0) begin
               state_d  = IDLE;
               cnt_d    = '0;
               primed_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Registered outputs.
   // Second-half advances emit the sum with twiddle index 0. First-half
   // advances emit the delay-line head, indexed by its position in the
   // frame, and mark it valid only when a previous frame filled the line.
   // Cycles without an advance emit nothing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_tw_idx <= '0;
         out_sof    <= 1'b0;
      end else if (advance) begin
         out_valid  <= phase1 || primed_q;
         out_data   <= phase1 ? sum_val : head;
         out_tw_idx <= phase1 ? '0 : cnt_q[AW-1:0];
         out_sof    <= (cnt_q == FIRST_P1);
      end else begin
         out_valid  <= 1'b0;
         out_sof    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sdf_butterfly.sv
// tb_sdf_butterfly
// Directed-vector bench for sdf_butterfly with DELAY = 4.
// Inputs change 1 time unit after each rising edge. Outputs are read
// 1 time unit after the edge that registered them.
module tb_sdf_butterfly;

   localparam int DELAY = 4;
   localparam int AW    = 2;

   // Hand-computed vectors for the back-to-back frame test
   localparam logic [23:0] F1  [8] = '{24'h100010, 24'h200010, 24'h300010, 24'h400010,
                                       24'h000030, 24'h000030, 24'h100030, 24'h100030};
   localparam logic [23:0] ES1 [4] = '{24'h080020, 24'h100020, 24'h200020, 24'h280020};
   localparam logic [23:0] ED1 [4] = '{24'h080FF0, 24'h100FF0, 24'h100FF0, 24'h180FF0};
   localparam logic [23:0] F2  [8] = '{24'h800000, 24'hF00000, 24'h000000, 24'h000000,
                                       24'h800000, 24'h100000, 24'h000000, 24'h000000};
   localparam logic [23:0] ES2 [4] = '{24'h800000, 24'h000000, 24'h000000, 24'h000000};
   localparam logic [23:0] ED2 [4] = '{24'h000000, 24'hF00000, 24'h000000, 24'h000000};

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [23:0]   in_data;
   logic          flush;
   logic          out_valid;
   logic [23:0]   out_data;
   logic [AW-1:0] out_tw_idx;
   logic          out_sof;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   sdf_butterfly #(.DELAY(DELAY), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_tw_idx(out_tw_idx),
      .out_sof   (out_sof)
   );

   // Output bundle {valid, data, idx, sof} as seen right now
   function automatic logic [27:0] obs();
      return {out_valid, out_data, out_tw_idx, out_sof};
   endfunction

   // Ramp sample k of a frame: re = (k+1)*0x010, im = 0
   function automatic logic [23:0] ramp(input int k);
      return {12'((k + 1) * 16), 12'h000};
   endfunction

   // Expected output for ramp cycle k in a primed steady-state frame.
   // Differences are always 0xFE0, and sums are 0x030 + 0x010*(k-4).
   function automatic logic [27:0] exp_ramp(input int k);
      if (k < 4) return {1'b1, 12'hFE0, 12'h000, AW'(k), 1'b0};
      return {1'b1, 12'((k - 1) * 16), 12'h000, 2'd0, (k == 4)};
   endfunction

   // Drive one clock cycle of input and return just after the edge
   task automatic apply_stimulus(input logic v, input logic [23:0] d, input logic f);
      in_valid = v;
      in_data  = d;
      flush    = f;
      @(posedge clk);
      #1;
      flush    = 1'b0;
   endtask

   // Flush, then let the drain run to completion
   task automatic flush_drain();
      apply_stimulus(1'b0, 24'h0, 1'b1);
      apply_stimulus(1'b0, 24'h0, 1'b0);
      repeat (DELAY) apply_stimulus(1'b0, 24'h0, 1'b0);
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      flush    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++;
      if ({obs(), in_ready} !== {28'h0, 1'b1})
         $display("[TB] FAIL reset_state: got %h ready %b, expected 0000000 ready 1", obs(), in_ready);
      else pass_cnt++;
      rst = 1'b0;
      apply_stimulus(1'b0, 24'h0, 1'b0);
   endtask

   task automatic test_basic_frame();
      for (int k = 0; k < 8; k++) begin
         apply_stimulus(1'b1, ramp(k), 1'b0);
         total_cnt++;
         if (k < 4) begin
            if (out_valid !== 1'b0)
               $display("[TB] FAIL basic_unprimed[%0d]: got valid %b, expected 0", k, out_valid);
            else pass_cnt++;
         end else begin
            if (obs() !== exp_ramp(k))
               $display("[TB] FAIL basic_sum[%0d]: got %h expected %h", k, obs(), exp_ramp(k));
            else pass_cnt++;
         end
      end
      apply_stimulus(1'b0, 24'h0, 1'b1);
      total_cnt++;
      if ({out_valid, in_ready} !== 2'b01)
         $display("[TB] FAIL basic_flush_req: got valid/ready %b%b, expected 01", out_valid, in_ready);
      else pass_cnt++;
      apply_stimulus(1'b0, 24'h0, 1'b0);
      total_cnt++;
      if ({out_valid, in_ready} !== 2'b00)
         $display("[TB] FAIL basic_drain_entry: got valid/ready %b%b, expected 00", out_valid, in_ready);
      else pass_cnt++;
      for (int j = 0; j < 4; j++) begin
         total_cnt++;
         if (in_ready !== 1'b0)
            $display("[TB] FAIL basic_drain_ready[%0d]: got %b expected 0", j, in_ready);
         else pass_cnt++;
         apply_stimulus(1'b0, 24'h0, 1'b0);
         total_cnt++;
         if (obs() !== {1'b1, 12'hFE0, 12'h000, AW'(j), 1'b0})
            $display("[TB] FAIL basic_diff[%0d]: got %h expected %h", j, obs(),
                     {1'b1, 12'hFE0, 12'h000, AW'(j), 1'b0});
         else pass_cnt++;
      end
      total_cnt++;
      if (in_ready !== 1'b1)
         $display("[TB] FAIL basic_idle_ready: got %b expected 1", in_ready);
      else pass_cnt++;
      apply_stimulus(1'b0, 24'h0, 1'b0);
      total_cnt++;
      if (out_valid !== 1'b0)
         $display("[TB] FAIL basic_idle_valid: got %b expected 0", out_valid);
      else pass_cnt++;
   endtask

   task automatic test_rounding();
      logic [11:0] exp_s;
      logic [11:0] exp_d;
      logic [11:0] re;
`ifdef SDF_ROUND_EN
      exp_s = 12'h002;
      exp_d = 12'h000;
`else
      exp_s = 12'h001;
      exp_d = 12'hFFF;
`endif
      for (int k = 0; k < 8; k++) begin
         re = (k == 0) ? 12'h001 : ((k == 4) ? 12'h002 : 12'h000);
         apply_stimulus(1'b1, {re, 12'h000}, 1'b0);
         if (k == 4) begin
            total_cnt++;
            if (obs() !== {1'b1, exp_s, 12'h000, 2'd0, 1'b1})
               $display("[TB] FAIL round_sum: got %h expected %h", obs(),
                        {1'b1, exp_s, 12'h000, 2'd0, 1'b1});
            else pass_cnt++;
         end
      end
      apply_stimulus(1'b1, 24'h0, 1'b0);
      total_cnt++;
      if (obs() !== {1'b1, exp_d, 12'h000, 2'd0, 1'b0})
         $display("[TB] FAIL round_diff: got %h expected %h", obs(),
                  {1'b1, exp_d, 12'h000, 2'd0, 1'b0});
      else pass_cnt++;
      for (int k = 1; k < 8; k++) apply_stimulus(1'b1, 24'h0, 1'b0);
      flush_drain();
   endtask

   task automatic test_back_to_back();
      logic [27:0] exp;
      for (int c = 0; c < 16; c++) begin
         apply_stimulus(1'b1, (c < 8) ? F1[c] : F2[c-8], 1'b0);
         total_cnt++;
         if (c < 4) begin
            if (out_valid !== 1'b0)
               $display("[TB] FAIL b2b_unprimed[%0d]: got valid %b expected 0", c, out_valid);
            else pass_cnt++;
         end else begin
            if (c < 8)       exp = {1'b1, ES1[c-4],  2'd0,       (c == 4)};
            else if (c < 12) exp = {1'b1, ED1[c-8],  AW'(c - 8), 1'b0};
            else             exp = {1'b1, ES2[c-12], 2'd0,       (c == 12)};
            if (obs() !== exp)
               $display("[TB] FAIL b2b_out[%0d]: got %h expected %h", c, obs(), exp);
            else pass_cnt++;
         end
      end
      apply_stimulus(1'b0, 24'h0, 1'b1);
      apply_stimulus(1'b0, 24'h0, 1'b0);
      total_cnt++;
      if (in_ready !== 1'b0)
         $display("[TB] FAIL b2b_drain_ready: got %b expected 0", in_ready);
      else pass_cnt++;
      for (int j = 0; j < 4; j++) begin
         apply_stimulus(1'b0, 24'h0, 1'b0);
         total_cnt++;
         if (obs() !== {1'b1, ED2[j], AW'(j), 1'b0})
            $display("[TB] FAIL b2b_drain[%0d]: got %h expected %h", j, obs(), {1'b1, ED2[j], AW'(j), 1'b0});
         else pass_cnt++;
      end
   endtask

   task automatic test_stalls();
      logic [25:0] got[$];
      logic [25:0] exp;
      logic        v;
      int          sent = 0;
      int          cyc  = 0;
      while (sent < 8 && cyc < 64) begin
         v = ((cyc % 3) != 1) && ($urandom_range(0, 3) != 0);
         apply_stimulus(v, v ? ramp(sent) : 24'h0, 1'b0);
         if (v) sent++;
         else begin
            total_cnt++;
            if (out_valid !== 1'b0)
               $display("[TB] FAIL stall_valid[cyc %0d]: got %b expected 0", cyc, out_valid);
            else pass_cnt++;
         end
         if (out_valid) got.push_back({out_data, out_tw_idx});
         cyc++;
      end
      total_cnt++;
      if (sent != 8)
         $display("[TB] FAIL stall_budget: got %0d samples sent, expected 8", sent);
      else pass_cnt++;
      apply_stimulus(1'b0, 24'h0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b0, 24'h0, 1'b0);
         if (out_valid) got.push_back({out_data, out_tw_idx});
      end
      total_cnt++;
      if (got.size() != 8)
         $display("[TB] FAIL stall_count: got %0d outputs, expected 8", got.size());
      else pass_cnt++;
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         exp = (i < 4) ? {12'((i + 3) * 16), 12'h000, 2'd0} : {12'hFE0, 12'h000, AW'(i - 4)};
         total_cnt++;
         if (got[i] !== exp)
            $display("[TB] FAIL stall_seq[%0d]: got %h expected %h", i, got[i], exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_flush_deferred();
      for (int k = 0; k < 8; k++) apply_stimulus(1'b1, ramp(k), 1'b0);
      for (int k = 0; k < 8; k++) begin
         apply_stimulus(1'b1, ramp(k), (k == 2));
         total_cnt++;
         if ({obs(), in_ready} !== {exp_ramp(k), 1'b1})
            $display("[TB] FAIL flush_midframe[%0d]: got %h ready %b, expected %h ready 1",
                     k, obs(), in_ready, exp_ramp(k));
         else pass_cnt++;
      end
      total_cnt++;
      if (in_ready !== 1'b1)
         $display("[TB] FAIL flush_boundary_ready: got %b expected 1", in_ready);
      else pass_cnt++;
      for (int k = 0; k < 8; k++) begin
         apply_stimulus(1'b1, ramp(k), 1'b0);
         total_cnt++;
         if (obs() !== exp_ramp(k))
            $display("[TB] FAIL flush_deferred_frame[%0d]: got %h expected %h", k, obs(), exp_ramp(k));
         else pass_cnt++;
      end
      apply_stimulus(1'b0, 24'h0, 1'b0);
      total_cnt++;
      if ({out_valid, in_ready} !== 2'b00)
         $display("[TB] FAIL flush_retry_drain: got valid/ready %b%b, expected 00", out_valid, in_ready);
      else pass_cnt++;
      for (int j = 0; j < 4; j++) begin
         apply_stimulus(1'b0, 24'h0, 1'b0);
         total_cnt++;
         if (obs() !== exp_ramp(j))
            $display("[TB] FAIL flush_drain[%0d]: got %h expected %h", j, obs(), exp_ramp(j));
         else pass_cnt++;
      end
      total_cnt++;
      if (in_ready !== 1'b1)
         $display("[TB] FAIL flush_end_ready: got %b expected 1", in_ready);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 8; k++) apply_stimulus(1'b1, ramp(k), 1'b0);
      for (int k = 0; k < 6; k++) apply_stimulus(1'b1, ramp(k), 1'b0);
      #2;
      rst = 1'b1;
      #1;
      total_cnt++;
      if ({obs(), in_ready} !== {28'h0, 1'b1})
         $display("[TB] FAIL reset_mid: got %h ready %b, expected 0000000 ready 1", obs(), in_ready);
      else pass_cnt++;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         apply_stimulus(1'b1, ramp(k), 1'b0);
         total_cnt++;
         if (k < 4) begin
            if (out_valid !== 1'b0)
               $display("[TB] FAIL reset_mid_unprimed[%0d]: got valid %b expected 0", k, out_valid);
            else pass_cnt++;
         end else begin
            if (obs() !== exp_ramp(k))
               $display("[TB] FAIL reset_mid_sum[%0d]: got %h expected %h", k, obs(), exp_ramp(k));
            else pass_cnt++;
         end
      end
      flush_drain();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_basic_frame();
      test_rounding();
      test_back_to_back();
      test_stalls();
      test_flush_deferred();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
